// File: rtl/uart_frame_ctrl.sv
// Frame parser for UART byte streams: SYNC(0xA5), LEN, payload, CHK, then a valid/ready unload.
// Optional inter-byte timeout is compiled in when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Pkt_Valid,
  input  logic       i_Pkt_Ready,
  output logic [7:0] o_Pkt_Data,
  output logic       o_Pkt_Last,
  output logic       o_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] GET_LEN     = 3'd1;
  localparam logic [2:0] GET_PAYLOAD = 3'd2;
  localparam logic [2:0] GET_CHK     = 3'd3;
  localparam logic [2:0] UNLOAD      = 3'd4;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam int unsigned IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;  // LEN-1
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [7:0]       acc_q, acc_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             buf_we;
  logic             tmo_hit;
  logic             rx_state;

  logic [7:0] mem [MAX_LEN];

  assign rx_state = (state_q == GET_LEN) || (state_q == GET_PAYLOAD) || (state_q == GET_CHK);
  assign buf_we   = (state_q == GET_PAYLOAD) && i_RX_DV;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] tmo_q, tmo_d;

  // A strobe in the same cycle as expiry wins and restarts the count.
  always_comb begin
    tmo_d   = 16'd0;
    tmo_hit = 1'b0;
    if (rx_state && !i_RX_DV) begin
      if (tmo_q == TMO_LAST) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    err_d      = 1'b0;
    ovr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC)) begin
          state_d = GET_LEN;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      GET_LEN: begin
        if (i_RX_DV) begin
          if ((i_RX_Byte != 8'd0) && (i_RX_Byte <= MAX_LEN_B)) begin
            state_d    = GET_PAYLOAD;
            last_idx_d = IDX_W'(i_RX_Byte - 8'd1);
            acc_d      = i_RX_Byte;
            cnt_d      = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      GET_PAYLOAD: begin
        if (i_RX_DV) begin
          acc_d = acc_q + i_RX_Byte;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == last_idx_q) begin
            state_d = GET_CHK;
          end
        end
      end
      GET_CHK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == acc_q) begin
            state_d = UNLOAD;
            k_d     = '0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      UNLOAD: begin
        ovr_d = i_RX_DV;
        if (i_Pkt_Ready) begin
          if (k_q == last_idx_q) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      last_idx_q <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      acc_q      <= 8'd0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  // Payload RAM is not reset; stale contents are never presented.
  always_ff @(posedge i_Clock) begin
    if (buf_we) begin
      mem[cnt_q] <= i_RX_Byte;
    end
  end

  assign o_Pkt_Valid = (state_q == UNLOAD);
  assign o_Pkt_Data  = o_Pkt_Valid ? mem[k_q] : 8'h00;
  assign o_Pkt_Last  = o_Pkt_Valid && (k_q == last_idx_q);
  assign o_Err       = err_q | tmo_hit;
  assign o_Overrun   = ovr_q;
  assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl; inputs change on falling edges.
module tb_uart_frame_ctrl;

  localparam int unsigned MaxLen  = 16;
  localparam int unsigned TmoClks = 8680;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       pkt_valid;
  logic       pkt_ready = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic       err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CLKS(TmoClks)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_l),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .o_Pkt_Valid(pkt_valid),
    .i_Pkt_Ready(pkt_ready),
    .o_Pkt_Data (pkt_data),
    .o_Pkt_Last (pkt_last),
    .o_Err      (err),
    .o_Overrun  (overrun),
    .o_Busy     (busy)
  );

  // Called at a falling edge; returns at the next falling edge (cycle after the strobe).
  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pkt_valid); end
    checks++; if (pkt_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", pkt_last); end
    checks++; if (pkt_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", pkt_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h69);
    for (int i = 0; i < 3; i++) begin
      checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL good_valid[%0d] got %b want 1", i, pkt_valid); end
      checks++; if (pkt_data !== exp_d[i]) begin errors++; $display("FAIL good_data[%0d] got %h want %h", i, pkt_data, exp_d[i]); end
      checks++; if (pkt_last !== (i == 2)) begin errors++; $display("FAIL good_last[%0d] got %b want %b", i, pkt_last, (i == 2)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err[%0d] got %b want 0", i, err); end
      @(negedge clk);
    end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL good_end_valid got %b want 0", pkt_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_end_busy got %b want 0", busy); end
  endtask

  task automatic test_bad_chk;
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20);
    send(8'h00);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badchk_err got %b want 1", err); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL badchk_valid got %b want 0", pkt_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badchk_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL badchk_err_pulse got %b want 0", err); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL badchk_valid2 got %b want 0", pkt_valid); end
  endtask

  task automatic test_bad_len;
    logic [7:0] lens [2];
    lens[0] = 8'h00; lens[1] = 8'h11;
    for (int i = 0; i < 2; i++) begin
      send(8'hA5);
      send(lens[i]);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL badlen_err[%0d] got %b want 1", i, err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen_busy[%0d] got %b want 0", i, busy); end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL badlen_pulse[%0d] got %b want 0", i, err); end
    end
  endtask

  task automatic test_sync_as_data;
    pkt_ready = 1'b1;
    // 0x02 + 0xA5 + 0xA5 = 0x14C
    send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5);
    send(8'h4C);
    for (int i = 0; i < 2; i++) begin
      checks++; if (pkt_data !== 8'hA5 || pkt_valid !== 1'b1) begin errors++; $display("FAIL a5data[%0d] got v=%b d=%h want v=1 d=a5", i, pkt_valid, pkt_data); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5data_busy got %b want 0", busy); end
  endtask

  task automatic test_max_len;
    int n_last;
    pkt_ready = 1'b1;
    n_last = 0;
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    // 0x10 + (0+1+...+15) = 0x10 + 0x78
    send(8'h88);
    for (int i = 0; i < 16; i++) begin
      checks++; if (pkt_valid !== 1'b1 || pkt_data !== 8'(i)) begin errors++; $display("FAIL maxlen_data[%0d] got v=%b d=%h want v=1 d=%h", i, pkt_valid, pkt_data, 8'(i)); end
      if (pkt_last === 1'b1) n_last++;
      if (i == 15) begin
        checks++; if (pkt_last !== 1'b1) begin errors++; $display("FAIL maxlen_last got %b want 1", pkt_last); end
      end
      @(negedge clk);
    end
    checks++; if (n_last != 1) begin errors++; $display("FAIL maxlen_last_count got %0d want 1", n_last); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL maxlen_end_valid got %b want 0", pkt_valid); end
  endtask

  task automatic test_stall_overrun;
    // Per cycle: ready/dv to drive, then expected valid/data/last/overrun observed first.
    logic       rdy [5];
    logic       dv  [5];
    logic       ev  [5];
    logic [7:0] ed  [5];
    logic       el  [5];
    logic       eo  [5];
    int         n_ovr;
    rdy[0]=0; dv[0]=1; ev[0]=1; ed[0]=8'h5A; el[0]=0; eo[0]=0;
    rdy[1]=1; dv[1]=0; ev[1]=1; ed[1]=8'h5A; el[1]=0; eo[1]=1;
    rdy[2]=0; dv[2]=0; ev[2]=1; ed[2]=8'hC3; el[2]=1; eo[2]=0;
    rdy[3]=1; dv[3]=0; ev[3]=1; ed[3]=8'hC3; el[3]=1; eo[3]=0;
    rdy[4]=0; dv[4]=0; ev[4]=0; ed[4]=8'h00; el[4]=0; eo[4]=0;
    n_ovr = 0;
    pkt_ready = 1'b0;
    // 0x02 + 0x5A + 0xC3 = 0x11F
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hC3);
    send(8'h1F);
    for (int i = 0; i < 5; i++) begin
      checks++; if (pkt_valid !== ev[i]) begin errors++; $display("FAIL stall_valid[%0d] got %b want %b", i, pkt_valid, ev[i]); end
      checks++; if (pkt_data !== ed[i]) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, pkt_data, ed[i]); end
      checks++; if (pkt_last !== el[i]) begin errors++; $display("FAIL stall_last[%0d] got %b want %b", i, pkt_last, el[i]); end
      checks++; if (overrun !== eo[i]) begin errors++; $display("FAIL stall_ovr[%0d] got %b want %b", i, overrun, eo[i]); end
      if (overrun === 1'b1) n_ovr++;
      pkt_ready = rdy[i];
      rx_dv     = dv[i];
      rx_byte   = 8'h55;
      @(negedge clk);
      rx_dv = 1'b0;
    end
    checks++; if (n_ovr != 1) begin errors++; $display("FAIL stall_ovr_count got %0d want 1", n_ovr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    int first_err;
    first_err = 0;
    send(8'hA5); send(8'h04);
    send(8'hAA);
    // Now in the cycle after the AA strobe (offset 1).
`ifdef UART_FRAME_TIMEOUT_EN
    for (int i = 1; i <= int'(TmoClks) + 2; i++) begin
      if (err === 1'b1 && first_err == 0) first_err = i;
      if (i == int'(TmoClks) + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
      end
      @(negedge clk);
    end
    checks++; if (first_err != int'(TmoClks)) begin errors++; $display("FAIL tmo_err_cycle got %0d want %0d", first_err, TmoClks); end
`else
    for (int i = 1; i <= int'(TmoClks) + 20; i++) begin
      if (err === 1'b1 && first_err == 0) first_err = i;
      @(negedge clk);
    end
    checks++; if (first_err != 0) begin errors++; $display("FAIL notmo_err got cycle %0d want none", first_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL notmo_busy got %b want 1", busy); end
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
`endif
  endtask

  task automatic test_reset_mid_payload;
    int n_err;
    n_err = 0;
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (err === 1'b1) n_err++;
    send(8'hA5); if (err === 1'b1) n_err++;
    send(8'h01); if (err === 1'b1) n_err++;
    send(8'h7E); if (err === 1'b1) n_err++;
    send(8'h7F);
    checks++; if (pkt_valid !== 1'b1 || pkt_data !== 8'h7E) begin errors++; $display("FAIL rstmid_data got v=%b d=%h want v=1 d=7e", pkt_valid, pkt_data); end
    checks++; if (pkt_last !== 1'b1) begin errors++; $display("FAIL rstmid_last got %b want 1", pkt_last); end
    if (err === 1'b1) n_err++;
    @(negedge clk);
    if (err === 1'b1) n_err++;
    checks++; if (n_err != 0) begin errors++; $display("FAIL rstmid_err got %0d pulses want 0", n_err); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_end_valid got %b want 0", pkt_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_sync_as_data();
    test_max_len();
    test_stall_overrun();
    test_timeout();
    test_reset_mid_payload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 8680, inter-byte timeout in i_Clock cycles (4 byte times at 217 clks/bit).
REQ-003 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_RX_DV  input  1  one-cycle strobe from the UART receiver marking a received byte.
REQ-006 SHALL have port i_RX_Byte  input  8  received byte, valid when i_RX_DV=1.
REQ-007 SHALL have port o_Pkt_Valid  output  1  payload byte available on o_Pkt_Data.
REQ-008 SHALL have port i_Pkt_Ready  input  1  consumer accepts the byte when o_Pkt_Valid=1.
REQ-009 SHALL have port o_Pkt_Data  output  8  payload byte.
REQ-010 SHALL have port o_Pkt_Last  output  1  marks the final payload byte, qualified by o_Pkt_Valid.
REQ-011 SHALL have port o_Err  output  1  one-cycle pulse: bad length, bad checksum, or timeout.
REQ-012 SHALL have port o_Overrun  output  1  one-cycle pulse: byte received and dropped during UNLOAD.
REQ-013 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL parse frames: SYNC byte 0xA5, LEN byte, LEN payload bytes, CHK byte, where CHK = (LEN + sum of payload) mod 256.
REQ-015 SHALL implement states IDLE, GET_LEN, GET_PAYLOAD, GET_CHK, UNLOAD; only i_RX_DV=1 cycles advance the receive states.
REQ-016 IDLE: byte 0xA5 -> GET_LEN; any other byte is discarded, with no o_Err.
REQ-017 GET_LEN: LEN in 1..MAX_LEN -> GET_PAYLOAD, with checksum accumulator loaded with LEN; LEN=0 or LEN>MAX_LEN -> o_Err pulse, then IDLE.
REQ-018 GET_PAYLOAD: each byte is written to an internal MAX_LEN x 8 buffer at index 0..LEN-1 and added mod 256 to the accumulator; after the LEN-th byte -> GET_CHK.
REQ-019 GET_CHK: on match -> UNLOAD; on mismatch -> o_Err pulse, then IDLE, with buffer contents never presented.
REQ-020 If the CHK byte strobes in cycle N, then in cycle N+1 the state SHALL be UNLOAD or IDLE, and o_Pkt_Valid or o_Err SHALL be high.
REQ-021 UNLOAD: o_Pkt_Valid=1 with buffer[k], k starting at 0; a transfer occurs on o_Pkt_Valid & i_Pkt_Ready; after a transfer, k advances and the next byte presents in the following cycle.
REQ-022 o_Pkt_Data and o_Pkt_Last SHALL hold stable while o_Pkt_Valid=1 and i_Pkt_Ready=0; o_Pkt_Valid SHALL NOT drop before the transfer.
REQ-023 o_Pkt_Last=1 only with byte LEN-1; after its transfer, o_Pkt_Valid=0 and the state is IDLE in the next cycle; with i_Pkt_Ready held high, throughput is 1 byte/cycle.
REQ-024 i_RX_DV=1 during UNLOAD: the byte is dropped, o_Overrun pulses the next cycle, and the unload continues unaffected.
REQ-025 A 0xA5 byte inside LEN, payload or CHK positions SHALL be treated as data, with no resync.

Reset
REQ-026 While i_Rst_L=0 at a clock edge: state <= IDLE, k, byte count, accumulator and timeout counter <= 0.
REQ-027 Output reset values: o_Pkt_Valid=0, o_Pkt_Last=0, o_Pkt_Data=0x00, o_Err=0, o_Overrun=0, o_Busy=0.
REQ-028 Reset mid-frame or mid-unload SHALL abandon the frame with no o_Err pulse; buffer RAM contents need not be cleared.

Configuration
REQ-029 Macro UART_FRAME_TIMEOUT_EN defined: in GET_LEN, GET_PAYLOAD or GET_CHK, a 16-bit counter SHALL clear on every i_RX_DV and increment otherwise.
REQ-030 When that counter reaches TIMEOUT_CLKS-1, the block SHALL pulse o_Err and return to IDLE; i_RX_DV in the same cycle wins and clears the counter.
REQ-031 Macro UART_FRAME_TIMEOUT_EN undefined: no timeout counter SHALL exist, and a stalled frame waits indefinitely in its state.

Verification
REQ-032 Bytes A5 03 11 22 33 69 with i_Pkt_Ready=1 -> 3 consecutive transfers 11,22,33, o_Pkt_Last on 33, no o_Err.
REQ-033 Bytes A5 02 10 20 00 -> o_Err pulse one cycle after CHK, o_Pkt_Valid stays 0, state IDLE.
REQ-034 Bytes A5 00 and A5 11 (MAX_LEN=16) -> o_Err pulse after each LEN byte, with IDLE following.
REQ-035 Good 2-byte frame with i_Pkt_Ready toggling 0/1 each cycle and a byte 0x55 injected during UNLOAD -> data held stable while stalled, one o_Overrun pulse, both bytes delivered in order.
REQ-036 With UART_FRAME_TIMEOUT_EN defined, A5 04 AA then silence -> o_Err exactly TIMEOUT_CLKS cycles after the AA strobe; without the macro -> no o_Err and o_Busy stays 1.
REQ-037 i_Rst_L=0 for one cycle mid-payload, then a good frame -> no o_Err, and the good frame is delivered intact.
